// File: rtl/sad_min_search.sv
// sad_min_search: streaming SAD engine with running best-match tracking.
// Four-stage pipeline: S1 absolute differences, S2 adder-tree row sum,
// S3 block accumulator, S4 completion outputs and best-match update.
module sad_min_search #(
   parameter int PIX_W = 8,
   parameter int LANES = 32,
   parameter int BEATS = 32,
   parameter int IDX_W = 16,
   localparam int SAD_W = PIX_W + $clog2(LANES * BEATS)
) (
   input  logic                   Bus2IP_Clk,
   input  logic                   Bus2IP_Reset,
   input  logic                   clr,
   input  logic                   in_valid,
   input  logic [PIX_W*LANES-1:0] in_face,
   input  logic [PIX_W*LANES-1:0] in_group,
   output logic                   sad_valid,
   output logic [SAD_W-1:0]       sad_out,
   output logic [IDX_W-1:0]       sad_idx,
   output logic                   best_valid,
   output logic [SAD_W-1:0]       best_sad,
   output logic [IDX_W-1:0]       best_idx
);

   localparam int LV    = $clog2(LANES);
   localparam int ROW_W = PIX_W + LV;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [SAD_W-1:0] SAD_ZERO  = {SAD_W{1'b0}};
   localparam logic [SAD_W-1:0] SAD_ONES  = {SAD_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);

   // |a - b| computed on PIX_W+1-bit zero-extended operands; result always fits PIX_W.
   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
      logic [PIX_W:0] d_ab;
      logic [PIX_W:0] d_ba;
      d_ab = {1'b0, a} - {1'b0, b};
      d_ba = {1'b0, b} - {1'b0, a};
      if (d_ab[PIX_W]) begin
         abs_diff = d_ba[PIX_W-1:0];
      end else begin
         abs_diff = d_ab[PIX_W-1:0];
      end
   endfunction

   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [PIX_W-1:0] abs_q [LANES];
   logic [PIX_W-1:0] abs_d [LANES];
   logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_first_q, s1_first_d;
   logic [ROW_W-1:0] row_sum;
   logic [ROW_W-1:0] row_q, row_d;
   logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_first_q, s2_first_d;
   logic [SAD_W-1:0] acc_q, acc_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] cand_q, cand_d;
   logic             sad_valid_q, sad_valid_d;
   logic [SAD_W-1:0] sad_out_q, sad_out_d;
   logic [IDX_W-1:0] sad_idx_q, sad_idx_d;
   logic             best_valid_q, best_valid_d;
   logic [SAD_W-1:0] best_sad_q, best_sad_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;

   // Balanced adder tree: level l holds LANES>>l partial sums, each one bit wider than the level below.
   for (genvar l = 0; l <= LV; l++) begin : tree_g
      logic [PIX_W+l-1:0] node [LANES>>l];
      if (l == 0) begin : leaf_g
         for (genvar j = 0; j < LANES; j++) begin : lane_g
            assign node[j] = abs_q[j];
         end
      end else begin : sum_g
         for (genvar j = 0; j < (LANES >> l); j++) begin : pair_g
            assign node[j] = {1'b0, tree_g[l-1].node[2*j]} + {1'b0, tree_g[l-1].node[2*j+1]};
         end
      end
   end
   assign row_sum = tree_g[LV].node[0];

   // Next-state logic for every pipeline stage; clr overrides and discards in-flight beats.
   always_comb begin
      beat_cnt_d   = beat_cnt_q;
      for (int k = 0; k < LANES; k++) begin
         abs_d[k] = abs_diff(in_face[k*PIX_W +: PIX_W], in_group[k*PIX_W +: PIX_W]);
      end
      s1_valid_d   = in_valid;
      s1_last_d    = (beat_cnt_q == LAST_BEAT);
      s1_first_d   = (beat_cnt_q == CNT_ZERO);
      row_d        = row_sum;
      s2_valid_d   = s1_valid_q;
      s2_last_d    = s1_last_q;
      s2_first_d   = s1_first_q;
      acc_d        = acc_q;
      done_d       = s2_valid_q & s2_last_q;
      cand_d       = cand_q;
      sad_valid_d  = done_q;
      sad_out_d    = sad_out_q;
      sad_idx_d    = sad_idx_q;
      best_valid_d = best_valid_q;
      best_sad_d   = best_sad_q;
      best_idx_d   = best_idx_q;
      if (clr) begin
         beat_cnt_d   = CNT_ZERO;
         s1_valid_d   = 1'b0;
         s2_valid_d   = 1'b0;
         done_d       = 1'b0;
         acc_d        = SAD_ZERO;
         cand_d       = IDX_ZERO;
         sad_valid_d  = 1'b0;
         best_valid_d = 1'b0;
         best_sad_d   = SAD_ONES;
         best_idx_d   = IDX_ZERO;
      end else begin
         if (in_valid) begin
            beat_cnt_d = s1_last_d ? CNT_ZERO : (beat_cnt_q + CNT_ONE);
         end else begin
            beat_cnt_d = beat_cnt_q;
         end
         if (s2_valid_q) begin
            acc_d = (s2_first_q ? SAD_ZERO : acc_q) + SAD_W'(row_q);
         end else begin
            acc_d = acc_q;
         end
         if (done_q) begin
            sad_out_d = acc_q;
            sad_idx_d = cand_q;
            cand_d    = cand_q + IDX_ONE;
            // Strict compare so a tie keeps the earlier candidate.
            if (!best_valid_q || (acc_q < best_sad_q)) begin
               best_valid_d = 1'b1;
               best_sad_d   = acc_q;
               best_idx_d   = cand_q;
            end else begin
               best_valid_d = best_valid_q;
            end
         end else begin
            cand_d = cand_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         beat_cnt_q <= CNT_ZERO;
         for (int k = 0; k < LANES; k++) begin
            abs_q[k] <= {PIX_W{1'b0}};
         end
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_first_q   <= 1'b0;
         row_q        <= {ROW_W{1'b0}};
         s2_valid_q   <= 1'b0;
         s2_last_q    <= 1'b0;
         s2_first_q   <= 1'b0;
         acc_q        <= SAD_ZERO;
         done_q       <= 1'b0;
         cand_q       <= IDX_ZERO;
         sad_valid_q  <= 1'b0;
         sad_out_q    <= SAD_ZERO;
         sad_idx_q    <= IDX_ZERO;
         best_valid_q <= 1'b0;
         best_sad_q   <= SAD_ONES;
         best_idx_q   <= IDX_ZERO;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         abs_q        <= abs_d;
         s1_valid_q   <= s1_valid_d;
         s1_last_q    <= s1_last_d;
         s1_first_q   <= s1_first_d;
         row_q        <= row_d;
         s2_valid_q   <= s2_valid_d;
         s2_last_q    <= s2_last_d;
         s2_first_q   <= s2_first_d;
         acc_q        <= acc_d;
         done_q       <= done_d;
         cand_q       <= cand_d;
         sad_valid_q  <= sad_valid_d;
         sad_out_q    <= sad_out_d;
         sad_idx_q    <= sad_idx_d;
         best_valid_q <= best_valid_d;
         best_sad_q   <= best_sad_d;
         best_idx_q   <= best_idx_d;
      end
   end

   assign sad_valid  = sad_valid_q;
   assign sad_out    = sad_out_q;
   assign sad_idx    = sad_idx_q;
   assign best_valid = best_valid_q;
   assign best_sad   = best_sad_q;
   assign best_idx   = best_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Testbench for sad_min_search: default-size instance plus a tiny
// LANES=2 / BEATS=1 / IDX_W=2 instance for index wrap and 1-beat blocks.
module tb_sad_min_search;

   localparam int PIX_W = 8, LANES = 32, BEATS = 32, IDX_W = 16, SAD_W = 18;
   localparam int W = PIX_W * LANES;
   localparam int S_LANES = 2, S_W = 16, S_IDX_W = 2, S_SAD_W = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clr, in_valid;
   logic [W-1:0] in_face, in_group;
   logic sad_valid, best_valid;
   logic [SAD_W-1:0] sad_out, best_sad;
   logic [IDX_W-1:0] sad_idx, best_idx;

   logic s_clr, s_in_valid;
   logic [S_W-1:0] s_face, s_group;
   logic s_sad_valid, s_best_valid;
   logic [S_SAD_W-1:0] s_sad_out, s_best_sad;
   logic [S_IDX_W-1:0] s_sad_idx, s_best_idx;

   sad_min_search #(.PIX_W(PIX_W), .LANES(LANES), .BEATS(BEATS), .IDX_W(IDX_W)) dut (
      .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .clr(clr), .in_valid(in_valid),
      .in_face(in_face), .in_group(in_group), .sad_valid(sad_valid), .sad_out(sad_out),
      .sad_idx(sad_idx), .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx));

   sad_min_search #(.PIX_W(PIX_W), .LANES(S_LANES), .BEATS(1), .IDX_W(S_IDX_W)) dut_s (
      .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .clr(s_clr), .in_valid(s_in_valid),
      .in_face(s_face), .in_group(s_group), .sad_valid(s_sad_valid), .sad_out(s_sad_out),
      .sad_idx(s_sad_idx), .best_valid(s_best_valid), .best_sad(s_best_sad), .best_idx(s_best_idx));

   int n_vec = 0, n_err = 0, cyc = 0, last_cyc = 0;
   int obs_sad[$], obs_idx[$], obs_bsad[$], obs_bidx[$], obs_cyc[$];
   bit obs_bv[$];
   int s_obs_sad[$], s_obs_idx[$], s_obs_bsad[$], s_obs_bidx[$], s_obs_cyc[$];
   int exp_sad[$], exp_idx[$], exp_bsad[$], exp_bidx[$];
   int m_acc, m_beats, m_cand, m_bsad, m_bidx, m_last_sad;
   bit m_bv;

   // Reference: row SAD as a plain integer sum of per-pixel distances.
   function automatic int row_sad(input logic [W-1:0] f, input logic [W-1:0] g, input int lanes);
      int s;
      s = 0;
      for (int k = 0; k < lanes; k++) begin
         int a, b;
         a = int'(f[k*PIX_W +: PIX_W]);
         b = int'(g[k*PIX_W +: PIX_W]);
         s += (a > b) ? (a - b) : (b - a);
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (sad_valid === 1'b1) begin
         obs_sad.push_back(int'(sad_out));   obs_idx.push_back(int'(sad_idx));
         obs_bsad.push_back(int'(best_sad)); obs_bidx.push_back(int'(best_idx));
         obs_bv.push_back(best_valid);       obs_cyc.push_back(cyc);
      end
      if (s_sad_valid === 1'b1) begin
         s_obs_sad.push_back(int'(s_sad_out));   s_obs_idx.push_back(int'(s_sad_idx));
         s_obs_bsad.push_back(int'(s_best_sad)); s_obs_bidx.push_back(int'(s_best_idx));
         s_obs_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic model_reset();
      m_acc = 0; m_beats = 0; m_cand = 0; m_bv = 1'b0; m_bsad = 0; m_bidx = 0;
      obs_sad.delete(); obs_idx.delete(); obs_bsad.delete(); obs_bidx.delete();
      obs_bv.delete(); obs_cyc.delete();
      exp_sad.delete(); exp_idx.delete(); exp_bsad.delete(); exp_bidx.delete();
   endtask

   task automatic do_clr();
      clr = 1'b1; in_valid = 1'b0;
      tick();
      clr = 1'b0;
      model_reset();
   endtask

   // One accepted beat; the model closes a candidate every BEATS accepted beats.
   task automatic beat(input logic [W-1:0] f, input logic [W-1:0] g);
      in_face = f; in_group = g; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      last_cyc = cyc;
      m_acc += row_sad(f, g, LANES);
      m_beats++;
      if (m_beats == BEATS) begin
         exp_sad.push_back(m_acc);
         exp_idx.push_back(m_cand);
         if (!m_bv || m_acc < m_bsad) begin
            m_bv = 1'b1; m_bsad = m_acc; m_bidx = m_cand;
         end
         exp_bsad.push_back(m_bsad);
         exp_bidx.push_back(m_bidx);
         m_last_sad = m_acc;
         m_cand = (m_cand + 1) % 65536;
         m_acc = 0; m_beats = 0;
      end
   endtask

   // A block with total SAD == target (random data when target < 0), optional idle gaps.
   task automatic send_block(input int target, input int gap_pct);
      int rem;
      rem = target;
      for (int b = 0; b < BEATS; b++) begin
         logic [W-1:0] f, g;
         for (int k = 0; k < LANES; k++) begin
            int d, base;
            if (target < 0) begin
               f[k*PIX_W +: PIX_W] = 8'($urandom);
               g[k*PIX_W +: PIX_W] = 8'($urandom);
            end else begin
               d = (rem > 255) ? 255 : rem;
               rem -= d;
               base = int'($urandom_range(0, 255 - d));
               if ($urandom_range(0, 1) == 1) begin
                  f[k*PIX_W +: PIX_W] = 8'(base + d); g[k*PIX_W +: PIX_W] = 8'(base);
               end else begin
                  f[k*PIX_W +: PIX_W] = 8'(base);     g[k*PIX_W +: PIX_W] = 8'(base + d);
               end
            end
         end
         beat(f, g);
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_face = '0; in_group = '0;
      s_clr = 1'b0; s_in_valid = 1'b0; s_face = '0; s_group = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_vec++; if (sad_valid !== 1'b0)  begin n_err++; $display("FAIL reset_sad_valid got %0b want 0", sad_valid); end
      n_vec++; if (sad_out !== 18'd0)   begin n_err++; $display("FAIL reset_sad_out got %0d want 0", sad_out); end
      n_vec++; if (sad_idx !== 16'd0)   begin n_err++; $display("FAIL reset_sad_idx got %0d want 0", sad_idx); end
      n_vec++; if (best_valid !== 1'b0) begin n_err++; $display("FAIL reset_best_valid got %0b want 0", best_valid); end
      n_vec++; if (best_sad !== 18'h3FFFF) begin n_err++; $display("FAIL reset_best_sad got %0h want 3ffff", best_sad); end
      n_vec++; if (best_idx !== 16'd0)  begin n_err++; $display("FAIL reset_best_idx got %0d want 0", best_idx); end
      n_vec++; if (s_best_sad !== 9'h1FF) begin n_err++; $display("FAIL reset_small_best_sad got %0h want 1ff", s_best_sad); end
      m_last_sad = 0;
      model_reset();
   endtask

   task automatic test_identical();
      do_clr();
      for (int b = 0; b < BEATS; b++) begin
         logic [W-1:0] f;
         f = {8{$urandom}};
         beat(f, f);
      end
      idle(6);
      n_vec++; if (obs_sad.size() != 1) begin n_err++; $display("FAIL ident_count got %0d want 1", obs_sad.size()); end
      if (obs_sad.size() > 0) begin
         n_vec++; if (obs_cyc[0] != last_cyc + 3) begin n_err++; $display("FAIL ident_latency got %0d want %0d", obs_cyc[0] - last_cyc, 3); end
         n_vec++; if (obs_sad[0] != 0)  begin n_err++; $display("FAIL ident_sad got %0d want 0", obs_sad[0]); end
         n_vec++; if (obs_idx[0] != 0)  begin n_err++; $display("FAIL ident_idx got %0d want 0", obs_idx[0]); end
         n_vec++; if (obs_bsad[0] != 0) begin n_err++; $display("FAIL ident_best_sad got %0d want 0", obs_bsad[0]); end
         n_vec++; if (obs_bv[0] !== 1'b1) begin n_err++; $display("FAIL ident_best_valid got %0b want 1", obs_bv[0]); end
      end
   endtask

   task automatic test_extremes();
      do_clr();
      for (int b = 0; b < BEATS; b++) beat({W{1'b1}}, {W{1'b0}});
      for (int b = 0; b < BEATS; b++) beat({W{1'b0}}, {W{1'b1}});
      idle(6);
      n_vec++; if (obs_sad.size() != 2) begin n_err++; $display("FAIL extreme_count got %0d want 2", obs_sad.size()); end
      for (int i = 0; i < obs_sad.size() && i < 2; i++) begin
         n_vec++; if (obs_sad[i] != 261120) begin n_err++; $display("FAIL extreme_sad[%0d] got %0d want 261120", i, obs_sad[i]); end
         n_vec++; if (obs_idx[i] != i)      begin n_err++; $display("FAIL extreme_idx[%0d] got %0d want %0d", i, obs_idx[i], i); end
         n_vec++; if (obs_bidx[i] != 0)     begin n_err++; $display("FAIL extreme_best_idx[%0d] got %0d want 0", i, obs_bidx[i]); end
      end
   endtask

   task automatic test_ties();
      int want[3];
      want = '{500, 300, 300};
      do_clr();
      send_block(500, 0);
      send_block(300, 20);
      send_block(300, 0);
      idle(6);
      n_vec++; if (obs_sad.size() != 3) begin n_err++; $display("FAIL ties_count got %0d want 3", obs_sad.size()); end
      for (int i = 0; i < obs_sad.size() && i < 3; i++) begin
         n_vec++; if (obs_sad[i] != want[i]) begin n_err++; $display("FAIL ties_sad[%0d] got %0d want %0d", i, obs_sad[i], want[i]); end
         n_vec++; if (obs_idx[i] != i)       begin n_err++; $display("FAIL ties_idx[%0d] got %0d want %0d", i, obs_idx[i], i); end
      end
      if (obs_sad.size() == 3) begin
         n_vec++; if (obs_bsad[2] != 300) begin n_err++; $display("FAIL ties_best_sad got %0d want 300", obs_bsad[2]); end
         n_vec++; if (obs_bidx[2] != 1)   begin n_err++; $display("FAIL ties_best_idx got %0d want 1", obs_bidx[2]); end
      end
   endtask

   task automatic test_random_gaps();
      do_clr();
      repeat (4) send_block(-1, 40);
      idle(6);
      n_vec++; if (obs_sad.size() != exp_sad.size()) begin n_err++; $display("FAIL gaps_count got %0d want %0d", obs_sad.size(), exp_sad.size()); end
      for (int i = 0; i < obs_sad.size() && i < exp_sad.size(); i++) begin
         n_vec++; if (obs_sad[i] != exp_sad[i])   begin n_err++; $display("FAIL gaps_sad[%0d] got %0d want %0d", i, obs_sad[i], exp_sad[i]); end
         n_vec++; if (obs_idx[i] != exp_idx[i])   begin n_err++; $display("FAIL gaps_idx[%0d] got %0d want %0d", i, obs_idx[i], exp_idx[i]); end
         n_vec++; if (obs_bsad[i] != exp_bsad[i]) begin n_err++; $display("FAIL gaps_best_sad[%0d] got %0d want %0d", i, obs_bsad[i], exp_bsad[i]); end
         n_vec++; if (obs_bidx[i] != exp_bidx[i]) begin n_err++; $display("FAIL gaps_best_idx[%0d] got %0d want %0d", i, obs_bidx[i], exp_bidx[i]); end
      end
   endtask

   task automatic test_back_to_back();
      do_clr();
      repeat (3) send_block(-1, 0);
      idle(6);
      n_vec++; if (obs_sad.size() != 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", obs_sad.size()); end
      for (int i = 0; i < obs_sad.size() && i < exp_sad.size(); i++) begin
         n_vec++; if (obs_sad[i] != exp_sad[i]) begin n_err++; $display("FAIL b2b_sad[%0d] got %0d want %0d", i, obs_sad[i], exp_sad[i]); end
         if (i > 0) begin
            n_vec++; if (obs_cyc[i] - obs_cyc[i-1] != BEATS) begin n_err++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], BEATS); end
         end
      end
   endtask

   task automatic test_clr_mid();
      int prev;
      prev = m_last_sad;
      do_clr();
      n_vec++; if (int'(sad_out) != prev) begin n_err++; $display("FAIL clr_keeps_sad_out got %0d want %0d", sad_out, prev); end
      n_vec++; if (best_valid !== 1'b0)   begin n_err++; $display("FAIL clr_best_valid got %0b want 0", best_valid); end
      n_vec++; if (best_sad !== 18'h3FFFF) begin n_err++; $display("FAIL clr_best_sad got %0h want 3ffff", best_sad); end
      for (int b = 0; b < 10; b++) beat({8{$urandom}}, {8{$urandom}});
      // clr together with a valid beat: the beat must be dropped
      clr = 1'b1; in_valid = 1'b1; in_face = {W{1'b1}}; in_group = {W{1'b0}};
      tick();
      clr = 1'b0; in_valid = 1'b0;
      model_reset();
      send_block(1000, 0);
      idle(6);
      n_vec++; if (obs_sad.size() != 1) begin n_err++; $display("FAIL clr_count got %0d want 1", obs_sad.size()); end
      if (obs_sad.size() > 0) begin
         n_vec++; if (obs_sad[0] != 1000)  begin n_err++; $display("FAIL clr_sad got %0d want 1000", obs_sad[0]); end
         n_vec++; if (obs_idx[0] != 0)     begin n_err++; $display("FAIL clr_idx got %0d want 0", obs_idx[0]); end
         n_vec++; if (obs_bsad[0] != 1000) begin n_err++; $display("FAIL clr_best_sad got %0d want 1000", obs_bsad[0]); end
      end
   endtask

   task automatic test_small_wrap();
      int e_sad[$], e_bsad[$], e_bidx[$];
      int bs, bi;
      bit bv;
      bv = 1'b0; bs = 0; bi = 0;
      for (int i = 0; i < 6; i++) begin
         int s;
         s_face = 16'($urandom); s_group = 16'($urandom); s_in_valid = 1'b1;
         tick();
         s = row_sad(W'(s_face), W'(s_group), S_LANES);
         if (!bv || s < bs) begin bv = 1'b1; bs = s; bi = i % 4; end
         e_sad.push_back(s); e_bsad.push_back(bs); e_bidx.push_back(bi);
      end
      s_in_valid = 1'b0;
      idle(6);
      n_vec++; if (s_obs_sad.size() != 6) begin n_err++; $display("FAIL small_count got %0d want 6", s_obs_sad.size()); end
      for (int i = 0; i < s_obs_sad.size() && i < 6; i++) begin
         n_vec++; if (s_obs_idx[i] != i % 4)      begin n_err++; $display("FAIL small_idx[%0d] got %0d want %0d", i, s_obs_idx[i], i % 4); end
         n_vec++; if (s_obs_sad[i] != e_sad[i])   begin n_err++; $display("FAIL small_sad[%0d] got %0d want %0d", i, s_obs_sad[i], e_sad[i]); end
         n_vec++; if (s_obs_bsad[i] != e_bsad[i]) begin n_err++; $display("FAIL small_best_sad[%0d] got %0d want %0d", i, s_obs_bsad[i], e_bsad[i]); end
         n_vec++; if (s_obs_bidx[i] != e_bidx[i]) begin n_err++; $display("FAIL small_best_idx[%0d] got %0d want %0d", i, s_obs_bidx[i], e_bidx[i]); end
         n_vec++; if (s_obs_cyc[i] != s_obs_cyc[0] + i) begin n_err++; $display("FAIL small_consecutive[%0d] got %0d want %0d", i, s_obs_cyc[i], s_obs_cyc[0] + i); end
      end
      n_vec++; if (s_best_valid !== 1'b1) begin n_err++; $display("FAIL small_best_valid got %0b want 1", s_best_valid); end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_extremes();
      test_ties();
      test_random_gaps();
      test_back_to_back();
      test_clr_mid();
      test_small_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
